beam_power_acc: RTL and testbench

BEAM_POWER_ACC -- requirements
Module: beam_power_acc

---
 rtl/beam_pwr_pkg.sv | 33 +++
 rtl/iq_mag_est.sv | 63 ++++++
 rtl/beam_power_acc.sv | 134 +++++++++++++
 tb/tb_beam_power_acc.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pwr_pkg.sv
// Shared types and default parameters for the per-beam RBG power accumulator.
package beam_pwr_pkg;

    typedef enum logic [1:0] {
        MAG_L1     = 2'd0,
        MAG_MAXMIN = 2'd1,
        MAG_MAX    = 2'd2
    } mag_mode_e;

    localparam int unsigned BEAM_DEF  = 16;
    localparam int unsigned IW_DEF    = 40;
    localparam int unsigned OW_DEF    = 40;
    localparam int unsigned SHIFT_DEF = 8;
    localparam int unsigned AW_DEF    = 8;
    localparam int unsigned LEN_W     = 8;

    // Per-RE framing flags travelling alongside the magnitude pipeline
    typedef struct packed {
        logic vld;
        logic start;
        logic close;
    } re_ctl_t;

    // Reserved encoding falls back to |I|+|Q|
    function automatic mag_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MAG_MAXMIN;
            2'd2:    return MAG_MAX;
            default: return MAG_L1;
        endcase
    endfunction

endpackage

// File: rtl/iq_mag_est.sv
// Two-stage magnitude estimator: shift+saturating abs, then mode combine.
module iq_mag_est
    import beam_pwr_pkg::*;
#(
    parameter int unsigned IW    = IW_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  mag_mode_e             i_mode,
    input  logic [IW-1:0]         i_re,
    input  logic [IW-1:0]         i_im,
    output logic [IW-SHIFT-1:0]   o_mag
);

    localparam int unsigned MW = IW - SHIFT;

    logic [MW-1:0] a_q, b_q, a_d, b_d;
    logic [MW-1:0] mag_q, mag_d;
    logic [MW-1:0] mx_c, mn_c;
    mag_mode_e     mode_q;
    logic          unused_lsb;

    // Arithmetic shift keeps only the upper bits; the sign extension is implicit
    assign unused_lsb = ^{i_re[SHIFT-1:0], i_im[SHIFT-1:0]};

    function automatic logic [MW-1:0] abs_sat(input logic [MW-1:0] x);
        if (!x[MW-1]) return x;
        if (x == {1'b1, {(MW-1){1'b0}}}) return {1'b0, {(MW-1){1'b1}}};
        return ~x + MW'(1);
    endfunction

    assign a_d = abs_sat(i_re[IW-1:SHIFT]);
    assign b_d = abs_sat(i_im[IW-1:SHIFT]);

    always_comb begin
        mx_c  = (a_q >= b_q) ? a_q : b_q;
        mn_c  = (a_q >= b_q) ? b_q : a_q;
        mag_d = a_q + b_q;
        case (mode_q)
            MAG_MAXMIN: mag_d = mx_c + (mn_c >> 1);
            MAG_MAX:    mag_d = mx_c;
            default:    mag_d = a_q + b_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MAG_L1;
            mag_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            mode_q <= i_mode;
            mag_q  <= mag_d;
        end
    end

    assign o_mag = mag_q;

endmodule

// File: rtl/beam_power_acc.sv
// Per-beam magnitude accumulation over resource-block groups, one sum per RBG close.
module beam_power_acc
    import beam_pwr_pkg::*;
#(
    parameter int unsigned BEAM  = BEAM_DEF,
    parameter int unsigned IW    = IW_DEF,
    parameter int unsigned OW    = OW_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [1:0]           i_mode,
    input  logic [LEN_W-1:0]     i_rbg_len,
    input  logic [BEAM*IW-1:0]   i_data_re,
    input  logic [BEAM*IW-1:0]   i_data_im,
    input  logic                 i_data_vld,
    input  logic                 i_data_sop,
    input  logic                 i_data_eop,
    output logic [BEAM*OW-1:0]   o_data_sum,
    output logic [AW-1:0]        o_data_addr,
    output logic                 o_data_vld,
    output logic [BEAM-1:0]      o_data_sat
);

    localparam int unsigned MW = IW - SHIFT;
    localparam int unsigned SW = ((OW > MW) ? OW : MW) + 1;
    localparam logic [OW-1:0] OW_MAX = '1;

    mag_mode_e           mode_q, mode_d, mode_c;
    logic [LEN_W-1:0]    len_q, len_d, len_c, last_c;
    logic [LEN_W-1:0]    cnt_q, cnt_d, cnt_c;
    logic [AW-1:0]       idx_q, idx_d, idx_c;
    logic                in_sym_q, in_sym_d;
    re_ctl_t             ctl_c, ctl1_q, ctl2_q;
    logic [AW-1:0]       idx1_q, idx2_q;

    logic [BEAM-1:0][OW-1:0] acc_q, acc_d;
    logic [BEAM-1:0]         sat_q, sat_d;

    // Framing: config is taken from the sop RE itself, then held for the symbol
    always_comb begin
        mode_c    = i_data_sop ? decode_mode(i_mode) : mode_q;
        len_c     = i_data_sop ? i_rbg_len : len_q;
        last_c    = (len_c == '0) ? '0 : len_c - LEN_W'(1);
        cnt_c     = i_data_sop ? '0 : cnt_q;
        idx_c     = i_data_sop ? '0 : idx_q;

        ctl_c       = '0;
        ctl_c.vld   = i_data_vld & (i_data_sop | in_sym_q);
        ctl_c.start = ctl_c.vld & (cnt_c == '0);
        ctl_c.close = ctl_c.vld & ((cnt_c == last_c) | i_data_eop);

        mode_d   = mode_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        in_sym_d = in_sym_q;
        if (ctl_c.vld) begin
            mode_d   = mode_c;
            len_d    = len_c;
            cnt_d    = ctl_c.close ? '0 : cnt_c + LEN_W'(1);
            idx_d    = ctl_c.close ? idx_c + AW'(1) : idx_c;
            in_sym_d = ~i_data_eop;
        end
    end

    for (genvar g = 0; g < BEAM; g++) begin : g_beam
        logic [MW-1:0] mag;
        logic [SW-1:0] sum_w;
        logic          ovf;

        iq_mag_est #(
            .IW    (IW),
            .SHIFT (SHIFT)
        ) u_mag (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_mode  (mode_c),
            .i_re    (i_data_re[g*IW +: IW]),
            .i_im    (i_data_im[g*IW +: IW]),
            .o_mag   (mag)
        );

        // First RE of an RBG restarts from zero and clears the sticky flag
        assign sum_w    = (ctl2_q.start ? SW'(0) : SW'(acc_q[g])) + SW'(mag);
        assign ovf      = (sum_w > SW'(OW_MAX));
        assign acc_d[g] = ovf ? OW_MAX : OW'(sum_w);
        assign sat_d[g] = ovf | (~ctl2_q.start & sat_q[g]);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mode_q      <= MAG_L1;
            len_q       <= LEN_W'(1);
            cnt_q       <= '0;
            idx_q       <= '0;
            in_sym_q    <= 1'b0;
            ctl1_q      <= '0;
            ctl2_q      <= '0;
            idx1_q      <= '0;
            idx2_q      <= '0;
            acc_q       <= '0;
            sat_q       <= '0;
            o_data_sum  <= '0;
            o_data_addr <= '0;
            o_data_vld  <= 1'b0;
            o_data_sat  <= '0;
        end else begin
            mode_q   <= mode_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            in_sym_q <= in_sym_d;
            ctl1_q   <= ctl_c;
            ctl2_q   <= ctl1_q;
            idx1_q   <= idx_c;
            idx2_q   <= idx1_q;

            o_data_vld <= 1'b0;
            if (ctl2_q.vld) begin
                acc_q <= acc_d;
                sat_q <= sat_d;
                if (ctl2_q.close) begin
                    o_data_vld  <= 1'b1;
                    o_data_sum  <= acc_d;
                    o_data_sat  <= sat_d;
                    o_data_addr <= idx2_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_beam_power_acc.sv
// Directed bench for beam_power_acc: framing, modes, saturation and reset.
module tb_beam_power_acc;

    localparam int unsigned NB = 16;
    localparam int unsigned W  = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        mode = '0;
    logic [7:0]        len = 8'd1;
    logic [NB*W-1:0]   re = '0;
    logic [NB*W-1:0]   im = '0;
    logic              vld = 1'b0, sop = 1'b0, eop = 1'b0;

    logic [NB*W-1:0]   sum;
    logic [7:0]        addr;
    logic              ovld;
    logic [NB-1:0]     sat;
    logic [NB*8-1:0]   sum8;
    logic [7:0]        addr8;
    logic              ovld8;
    logic [NB-1:0]     sat8;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        int          cyc;
        logic        v0;
        logic        v8;
        logic [39:0] s0;
        logic [39:0] s15;
        logic [7:0]  addr;
        logic        sat0;
        logic [7:0]  s8;
        logic        sat8;
    } ev_t;
    ev_t evq[$];

    beam_power_acc dut (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_rbg_len(len),
        .i_data_re(re), .i_data_im(im), .i_data_vld(vld), .i_data_sop(sop), .i_data_eop(eop),
        .o_data_sum(sum), .o_data_addr(addr), .o_data_vld(ovld), .o_data_sat(sat)
    );

    beam_power_acc #(.OW(8)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_rbg_len(len),
        .i_data_re(re), .i_data_im(im), .i_data_vld(vld), .i_data_sop(sop), .i_data_eop(eop),
        .o_data_sum(sum8), .o_data_addr(addr8), .o_data_vld(ovld8), .o_data_sat(sat8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ovld || ovld8)
            evq.push_back('{cyc, ovld, ovld8, sum[39:0], sum[15*W +: W], addr, sat[0],
                            sum8[7:0], sat8[0]});
    end

    // One RE; n is the negedge index just before the capturing edge
    task automatic put(input logic s, input logic e, input logic [1:0] md, input logic [7:0] ln,
                       input logic [39:0] i0, input logic [39:0] q0, output int n);
        @(posedge clk); #1;
        vld = 1'b1; sop = s; eop = e; mode = md; len = ln;
        re[39:0] = i0; im[39:0] = q0;
        n = cyc + 1;
    endtask

    task automatic gap(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            vld = 1'b0; sop = 1'b0; eop = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (ovld !== 1'b0 || sum !== '0 || addr !== 8'd0 || sat !== '0 || sum8 !== '0) begin
            nerr++;
            $display("FAIL reset_outputs vld=%0b sum0=%0d addr=%0d sat=%h want all zero",
                     ovld, sum[39:0], addr, sat);
        end
        rst = 1'b0;
        evq.delete();
        put(1'b0, 1'b0, 2'd0, 8'd1, 40'h100, 40'h100, n);
        put(1'b0, 1'b0, 2'd0, 8'd1, 40'h100, 40'h100, n);
        put(1'b0, 1'b1, 2'd0, 8'd1, 40'h100, 40'h100, n);
        gap(6);
        nvec++;
        if (evq.size() != 0) begin
            nerr++;
            $display("FAIL reset_no_sop events=%0d want 0", evq.size());
        end
    endtask

    task automatic test_l1();
        int n[8];
        evq.delete();
        re[15*W +: W] = -40'sd4096;
        im[15*W +: W] = '0;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) gap(1);
            put(k == 0, k == 7, 2'd0, 8'd4, 40'd256, -40'sd512, n[k]);
        end
        gap(6);
        re[15*W +: W] = '0;
        nvec++;
        if (evq.size() != 2) begin
            nerr++;
            $display("FAIL l1_count got %0d want 2", evq.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (evq[k].v0 !== 1'b1 || evq[k].s0 !== 40'd12 || evq[k].addr !== 8'(k) ||
                    evq[k].cyc != n[4*k+3] + 3 || evq[k].s15 !== 40'd64) begin
                    nerr++;
                    $display("FAIL l1_rbg%0d sum=%0d addr=%0d cyc=%0d s15=%0d want 12/%0d/%0d/64",
                             k, evq[k].s0, evq[k].addr, evq[k].cyc, evq[k].s15, k, n[4*k+3] + 3);
                end
            end
        end
    endtask

    task automatic test_modes();
        int n[10];
        int es[6] = '{6, 6, 8, 8, 4, 4};
        int ea[6] = '{0, 0, 0, 1, 0, 1};
        int ec[6];
        evq.delete();
        put(1'b1, 1'b0, 2'd1, 8'd2, 40'h300, 40'h100, n[0]);
        put(1'b0, 1'b1, 2'd1, 8'd2, 40'h300, 40'h100, n[1]);
        put(1'b1, 1'b0, 2'd2, 8'd2, 40'h300, 40'h100, n[2]);
        put(1'b0, 1'b1, 2'd2, 8'd2, 40'h300, 40'h100, n[3]);
        put(1'b1, 1'b0, 2'd1, 8'd2, 40'h300, 40'h200, n[4]);
        put(1'b0, 1'b0, 2'd2, 8'd4, 40'h300, 40'h200, n[5]);
        put(1'b0, 1'b0, 2'd2, 8'd4, 40'h300, 40'h200, n[6]);
        put(1'b0, 1'b1, 2'd2, 8'd4, 40'h300, 40'h200, n[7]);
        put(1'b1, 1'b0, 2'd3, 8'd0, 40'h300, 40'h100, n[8]);
        put(1'b0, 1'b1, 2'd3, 8'd0, 40'h300, 40'h100, n[9]);
        gap(6);
        ec = '{n[1] + 3, n[3] + 3, n[5] + 3, n[7] + 3, n[8] + 3, n[9] + 3};
        nvec++;
        if (evq.size() != 6) begin
            nerr++;
            $display("FAIL modes_count got %0d want 6", evq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                nvec++;
                if (evq[k].s0 !== 40'(es[k]) || evq[k].addr !== 8'(ea[k]) || evq[k].cyc != ec[k]) begin
                    nerr++;
                    $display("FAIL modes_ev%0d sum=%0d addr=%0d cyc=%0d want %0d/%0d/%0d",
                             k, evq[k].s0, evq[k].addr, evq[k].cyc, es[k], ea[k], ec[k]);
                end
            end
        end
    endtask

    task automatic test_eop_partial();
        int n[9];
        evq.delete();
        for (int k = 0; k < 6; k++)
            put(k == 0, k == 5, 2'd0, 8'd4, 40'd256, -40'sd512, n[k]);
        for (int k = 6; k < 9; k++)
            put(1'b0, 1'b0, 2'd0, 8'd4, 40'd256, -40'sd512, n[k]);
        gap(6);
        nvec++;
        if (evq.size() != 2) begin
            nerr++;
            $display("FAIL eop_count got %0d want 2", evq.size());
        end else begin
            nvec++;
            if (evq[0].s0 !== 40'd12 || evq[0].addr !== 8'd0 || evq[0].cyc != n[3] + 3) begin
                nerr++;
                $display("FAIL eop_full sum=%0d addr=%0d cyc=%0d want 12/0/%0d",
                         evq[0].s0, evq[0].addr, evq[0].cyc, n[3] + 3);
            end
            nvec++;
            if (evq[1].s0 !== 40'd6 || evq[1].addr !== 8'd1 || evq[1].cyc != n[5] + 3) begin
                nerr++;
                $display("FAIL eop_partial sum=%0d addr=%0d cyc=%0d want 6/1/%0d",
                         evq[1].s0, evq[1].addr, evq[1].cyc, n[5] + 3);
            end
        end
    endtask

    task automatic test_sop_restart();
        int n[6];
        evq.delete();
        for (int k = 0; k < 6; k++)
            put(k == 0 || k == 2, k == 5, 2'd0, 8'd4, 40'd256, -40'sd512, n[k]);
        gap(6);
        nvec++;
        if (evq.size() != 1) begin
            nerr++;
            $display("FAIL restart_count got %0d want 1", evq.size());
        end else begin
            nvec++;
            if (evq[0].s0 !== 40'd12 || evq[0].addr !== 8'd0 || evq[0].cyc != n[5] + 3) begin
                nerr++;
                $display("FAIL restart_sum sum=%0d addr=%0d cyc=%0d want 12/0/%0d",
                         evq[0].s0, evq[0].addr, evq[0].cyc, n[5] + 3);
            end
        end
    endtask

    task automatic test_single_and_absmax();
        int n[2];
        evq.delete();
        put(1'b1, 1'b1, 2'd0, 8'd4, 40'd256, -40'sd512, n[0]);
        put(1'b1, 1'b1, 2'd2, 8'd4, 40'h80_0000_0000, 40'd0, n[1]);
        gap(6);
        nvec++;
        if (evq.size() != 2) begin
            nerr++;
            $display("FAIL single_count got %0d want 2", evq.size());
        end else begin
            nvec++;
            if (evq[0].s0 !== 40'd3 || evq[0].addr !== 8'd0 || evq[0].cyc != n[0] + 3) begin
                nerr++;
                $display("FAIL single_re sum=%0d addr=%0d cyc=%0d want 3/0/%0d",
                         evq[0].s0, evq[0].addr, evq[0].cyc, n[0] + 3);
            end
            nvec++;
            if (evq[1].s0 !== 40'h7FFF_FFFF || evq[1].sat0 !== 1'b0 || evq[1].addr !== 8'd0 ||
                evq[1].s8 !== 8'd255 || evq[1].sat8 !== 1'b1) begin
                nerr++;
                $display("FAIL abs_most_neg sum=%h sat=%0b addr=%0d s8=%0d sat8=%0b want 7fffffff/0/0/255/1",
                         evq[1].s0, evq[1].sat0, evq[1].addr, evq[1].s8, evq[1].sat8);
            end
        end
    endtask

    task automatic test_saturation();
        int n[8];
        evq.delete();
        for (int k = 0; k < 8; k++) begin
            if (k < 4) put(k == 0, 1'b0, 2'd0, 8'd4, 40'h6400, 40'h6400, n[k]);
            else       put(1'b0, k == 7, 2'd0, 8'd4, 40'h500, 40'h500, n[k]);
        end
        gap(6);
        nvec++;
        if (evq.size() != 2) begin
            nerr++;
            $display("FAIL sat_count got %0d want 2", evq.size());
        end else begin
            nvec++;
            if (evq[0].v8 !== 1'b1 || evq[0].s8 !== 8'd255 || evq[0].sat8 !== 1'b1 ||
                evq[0].s0 !== 40'd800 || evq[0].sat0 !== 1'b0 || evq[0].cyc != n[3] + 3) begin
                nerr++;
                $display("FAIL sat_clamp s8=%0d sat8=%0b s40=%0d sat40=%0b cyc=%0d want 255/1/800/0/%0d",
                         evq[0].s8, evq[0].sat8, evq[0].s0, evq[0].sat0, evq[0].cyc, n[3] + 3);
            end
            nvec++;
            if (evq[1].s8 !== 8'd40 || evq[1].sat8 !== 1'b0 || evq[1].s0 !== 40'd40 ||
                evq[1].addr !== 8'd1 || evq[1].cyc != n[7] + 3) begin
                nerr++;
                $display("FAIL sat_recover s8=%0d sat8=%0b s40=%0d addr=%0d cyc=%0d want 40/0/40/1/%0d",
                         evq[1].s8, evq[1].sat8, evq[1].s0, evq[1].addr, evq[1].cyc, n[7] + 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n[5];
        int m;
        for (int k = 0; k < 5; k++)
            put(k == 0, 1'b0, 2'd0, 8'd2, 40'd256, -40'sd512, n[k]);
        gap(5);
        nvec++;
        if (ovld !== 1'b0 || sum[39:0] !== 40'd6 || addr !== 8'd1) begin
            nerr++;
            $display("FAIL hold_outputs vld=%0b sum=%0d addr=%0d want 0/6/1", ovld, sum[39:0], addr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        nvec++;
        if (ovld !== 1'b0 || sum !== '0 || addr !== 8'd0 || sat !== '0 || sum8 !== '0) begin
            nerr++;
            $display("FAIL reset_async vld=%0b sum0=%0d addr=%0d want 0/0/0", ovld, sum[39:0], addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        evq.delete();
        put(1'b0, 1'b0, 2'd0, 8'd2, 40'd256, -40'sd512, m);
        put(1'b0, 1'b0, 2'd0, 8'd2, 40'd256, -40'sd512, m);
        put(1'b0, 1'b1, 2'd0, 8'd2, 40'd256, -40'sd512, m);
        put(1'b1, 1'b0, 2'd0, 8'd2, 40'd256, -40'sd512, m);
        put(1'b0, 1'b1, 2'd0, 8'd2, 40'd256, -40'sd512, m);
        gap(6);
        nvec++;
        if (evq.size() != 1) begin
            nerr++;
            $display("FAIL post_reset_count got %0d want 1", evq.size());
        end else begin
            nvec++;
            if (evq[0].s0 !== 40'd6 || evq[0].addr !== 8'd0 || evq[0].cyc != m + 3) begin
                nerr++;
                $display("FAIL post_reset_sum sum=%0d addr=%0d cyc=%0d want 6/0/%0d",
                         evq[0].s0, evq[0].addr, evq[0].cyc, m + 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_l1();
        test_modes();
        test_eop_partial();
        test_sop_restart();
        test_single_and_absmax();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
